i2s_audio_tx: RTL

- Stereo I2S transmitter clocked by the 3.072 MHz audio PLL output.
- Its `locked` output gates this block.
- Generates BCLK/LRCLK from the audio clock, buffers left/right sample pairs in a 4-entry FIFO with a valid/ready input, and serializes them MSB-first in Philips I2S format to the external DAC.
- Defaults: BCLK = 1.536 MHz, 16-bit slots, 48 kHz frame rate.

---
 rtl/i2s_audio_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_audio_tx.sv
// Stereo Philips-I2S transmitter.
// Generates BCLK/LRCLK from the audio clock, buffers {left, right} sample pairs in a small
// FIFO and shifts them out MSB-first with the one-BCLK I2S data delay.
// Optional build macro: I2S_AUDIO_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module i2s_audio_tx #(
    parameter int unsigned SW         = 16,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            locked,
    input  logic            enable,
    input  logic [2*SW-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            underrun_clr,
    output logic            underrun,
    output logic            bclk,
    output logic            lrclk,
    output logic            sdata
`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]     underrun_cnt
`endif
);

    localparam int unsigned FW = 2 * SW;
    localparam int unsigned BW = $clog2(FW);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [BW-1:0] BitLast = BW'(FW - 1);
    localparam logic [BW-1:0] BitHalf = BW'(SW);
    localparam logic [BW-1:0] BitOne  = BW'(1);
    localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] bit_nxt;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic          underrun_q, underrun_d;
    logic          underrun_set;

    // Sample-pair FIFO; pointers carry one extra wrap bit to tell full from empty.
    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          full, empty, push, pop;
    logic [FW-1:0] frame;
    logic          run_ok;

    assign run_ok   = enable && locked;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push     = in_valid && !full;
    assign in_ready = !full;
    // An empty FIFO at load time sends a silent frame; a same-cycle write is not bypassed.
    assign frame    = empty ? '0 : mem_q[rptr_q[PW-1:0]];

    // FIFO storage: data needs no reset, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PW-1:0]] <= in_data;
        end
    end

    // Pointer next state; push and pop may both happen in one cycle.
    always_comb begin
        wptr_d = push ? wptr_q + (PW + 1)'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + (PW + 1)'(1) : rptr_q;
    end

    // Sequencer: divider, bit counter, frame shifter and IDLE/RUN control.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bclk_d       = bclk_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        shreg_d      = shreg_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        bit_nxt      = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitOne;
        case (state_q)
            StIdle: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                if (run_ok) begin
                    state_d = StRun;
                end
            end
            default: begin
                if (!run_ok) begin
                    // Abort mid-frame; the FIFO head is left in place.
                    state_d   = StIdle;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    bclk_d    = 1'b0;
                    lrclk_d   = 1'b0;
                    sdata_d   = 1'b0;
                end else if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    bclk_d    = !bclk_q;
                    // Falling BCLK edge: the only point where lrclk/sdata move.
                    if (bclk_q) begin
                        bit_cnt_d = bit_nxt;
                        lrclk_d   = (bit_nxt >= BitHalf);
                        if (bit_nxt == BitOne) begin
                            pop          = !empty;
                            underrun_set = empty;
                            sdata_d      = frame[FW-1];
                            shreg_d      = {frame[FW-2:0], 1'b0};
                        end else begin
                            sdata_d = shreg_q[FW-1];
                            shreg_d = {shreg_q[FW-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
        endcase
    end

    // Sticky underrun flag; a new event beats a clear in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            shreg_q    <= shreg_d;
            underrun_q <= underrun_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

`ifdef I2S_AUDIO_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating underrun event counter; an increment beats a clear and restarts at 1.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_set) begin
            if (underrun_clr) begin
                ucnt_d = 16'd1;
            end else if (ucnt_q != 16'hFFFF) begin
                ucnt_d = ucnt_q + 16'd1;
            end
        end else if (underrun_clr) begin
            ucnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule
